// File: rtl/mem_stage.sv
// Memory-access stage: word-addressed data memory, branch resolution,
// multi-cycle access stall FSM and the MEM/WB pipeline register.
module mem_stage #(
  parameter int ADDR_W  = 8,
  parameter int MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        RegWrite_in,
  input  logic [1:0]  MemtoReg_in,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic        Branch,
  input  logic        Zero,
  input  logic [31:0] ALU,
  input  logic [31:0] RD2,
  input  logic [4:0]  WN,
  input  logic [31:0] PC_ADD,
  input  logic [31:0] pc_next_in,
  output logic        PCSrc,
  output logic [31:0] branch_target,
  output logic        stall,
  output logic        misalign,
  output logic        RegWrite_out,
  output logic [1:0]  MemtoReg_out,
  output logic [31:0] RD_out,
  output logic [31:0] ALU_out,
  output logic [4:0]  WN_out,
  output logic [31:0] pc_next_out
);

  // MEM_LAT-1 is the largest value the counter ever holds.
  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam bit MULTI = (MEM_LAT > 1);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic               commit;

  logic [31:0]        mem [2**ADDR_W];
  logic [ADDR_W-1:0]  idx;
  logic               aligned;
  logic               req;
  logic               access;
  logic               is_load;
  logic               is_store;
  logic [31:0]        mem_rd;

  // Address decode; upper address bits are dropped so accesses wrap.
  assign idx      = ALU[ADDR_W+1:2];
  assign aligned  = (ALU[1:0] == 2'b00);
  assign req      = MemRead | MemWrite;
  assign access   = req & aligned;
  // Both request bits high is a store; the load path then returns zero.
  assign is_store = MemWrite & aligned;
  assign is_load  = MemRead & ~MemWrite & aligned;
  assign mem_rd   = mem[idx];

  // Branch resolution is independent of the memory; suppressed while frozen.
  assign branch_target = PC_ADD;
  assign PCSrc         = Branch & Zero & ~stall;

  // FSM state and latency counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= CNT_ZERO;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state: IDLE launches a multi-cycle access, BUSY counts it down.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (access && MULTI) begin
          state_nxt = BUSY;
          cnt_nxt   = CNT_INIT;
        end
      end
      BUSY: begin
        if (cnt > CNT_ONE) begin
          cnt_nxt = cnt - CNT_ONE;
        end else begin
          state_nxt = IDLE;
          cnt_nxt   = CNT_ZERO;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = CNT_ZERO;
      end
    endcase
  end

  // Outputs: stall until the final access cycle, which is the commit cycle.
  always_comb begin
    stall = 1'b0;
    case (state)
      IDLE:    stall = access && MULTI;
      BUSY:    stall = (cnt > CNT_ONE);
      default: stall = 1'b0;
    endcase
    commit = ~stall;
  end

  // Data memory write; no reset so contents survive, and a reset on the
  // commit edge aborts the pending store.
  always_ff @(posedge clk) begin
    if (!reset && commit && is_store)
      mem[idx] <= RD2;
  end

  // MEM/WB register: real instruction on commit, bubble while stalled.
  always_ff @(posedge clk) begin
    if (reset || !commit) begin
      RegWrite_out <= 1'b0;
      MemtoReg_out <= 2'b00;
      RD_out       <= 32'h0;
      ALU_out      <= 32'h0;
      WN_out       <= 5'd0;
      pc_next_out  <= 32'h0;
      misalign     <= 1'b0;
    end else begin
      RegWrite_out <= RegWrite_in;
      MemtoReg_out <= MemtoReg_in;
      RD_out       <= is_load ? mem_rd : 32'h0;
      ALU_out      <= ALU;
      WN_out       <= WN;
      pc_next_out  <= pc_next_in;
      misalign     <= req & ~aligned;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: three instances (latency 1, 3, 4) checked against a
// transaction-level model of memory contents and stall/bubble timing.
module tb_mem_stage;

  logic clk = 1'b0;
  logic reset;

  logic        rw_in  [3];
  logic [1:0]  mtr_in [3];
  logic        mr     [3];
  logic        mw     [3];
  logic        br     [3];
  logic        zf     [3];
  logic [31:0] alu    [3];
  logic [31:0] rd2    [3];
  logic [4:0]  wn     [3];
  logic [31:0] pca    [3];
  logic [31:0] pcn    [3];

  logic        pcsrc  [3];
  logic [31:0] btgt   [3];
  logic        stl    [3];
  logic        mis    [3];
  logic        rw_o   [3];
  logic [1:0]  mtr_o  [3];
  logic [31:0] rd_o   [3];
  logic [31:0] alu_o  [3];
  logic [4:0]  wn_o   [3];
  logic [31:0] pcn_o  [3];

  int total = 0;
  int bad   = 0;

  logic [31:0] mem_m [3][256];
  bit          known [3][256];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 1 : ((g == 1) ? 3 : 4);
    mem_stage #(.ADDR_W(8), .MEM_LAT(LAT)) dut (
      .clk(clk), .reset(reset),
      .RegWrite_in(rw_in[g]), .MemtoReg_in(mtr_in[g]),
      .MemRead(mr[g]), .MemWrite(mw[g]), .Branch(br[g]), .Zero(zf[g]),
      .ALU(alu[g]), .RD2(rd2[g]), .WN(wn[g]), .PC_ADD(pca[g]),
      .pc_next_in(pcn[g]),
      .PCSrc(pcsrc[g]), .branch_target(btgt[g]), .stall(stl[g]),
      .misalign(mis[g]), .RegWrite_out(rw_o[g]), .MemtoReg_out(mtr_o[g]),
      .RD_out(rd_o[g]), .ALU_out(alu_o[g]), .WN_out(wn_o[g]),
      .pc_next_out(pcn_o[g])
    );
  end

  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : ((d == 1) ? 3 : 4);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_all();
    for (int i = 0; i < 3; i++) begin
      rw_in[i] = 0; mtr_in[i] = 0; mr[i] = 0; mw[i] = 0; br[i] = 0; zf[i] = 0;
      alu[i] = 0; rd2[i] = 0; wn[i] = 0; pca[i] = 0; pcn[i] = 0;
    end
  endtask

  task automatic rand_all();
    for (int i = 0; i < 3; i++) begin
      rw_in[i] = 1'($urandom); mtr_in[i] = 2'($urandom); mr[i] = 1'($urandom);
      mw[i] = 1'($urandom); br[i] = 1'($urandom); zf[i] = 1'($urandom);
      alu[i] = $urandom; rd2[i] = $urandom; wn[i] = 5'($urandom);
      pca[i] = $urandom; pcn[i] = $urandom;
    end
  endtask

  // One instruction through DUT d, entered just after a rising edge.
  // The model says: an aligned memory request occupies lat cycles, of which
  // the first lat-1 stall and deliver bubbles; then MEM/WB shows the result.
  task automatic txn(input int d, input bit w, input logic [1:0] m,
                     input bit rd, input bit wr, input bit b, input bit z,
                     input logic [31:0] a, input logic [31:0] data,
                     input logic [4:0] n, input logic [31:0] tgt,
                     input logic [31:0] pn);
    bit          algn, acc, chk_rd;
    int          idx, nst;
    logic [31:0] exp_rd;
    algn   = (a[1:0] == 2'b00);
    acc    = (rd | wr) && algn;
    idx    = int'(a[9:2]);
    nst    = acc ? lat_of(d) - 1 : 0;
    chk_rd = 1;
    exp_rd = 32'h0;
    if (rd && !wr && algn) begin
      exp_rd = mem_m[d][idx];
      chk_rd = known[d][idx];
    end
    idle_all();
    rw_in[d] = w; mtr_in[d] = m; mr[d] = rd; mw[d] = wr; br[d] = b; zf[d] = z;
    alu[d] = a; rd2[d] = data; wn[d] = n; pca[d] = tgt; pcn[d] = pn;
    for (int k = 0; k < nst; k++) begin
      #1;
      chk("stall_hi", 32'(stl[d]), 32'd1);
      chk("pcsrc_stalled", 32'(pcsrc[d]), 32'd0);
      @(posedge clk); #1;
      chk("bubble_rw", 32'(rw_o[d]), 32'd0);
      chk("bubble_alu", alu_o[d], 32'h0);
      chk("bubble_wn", 32'(wn_o[d]), 32'd0);
    end
    #1;
    chk("stall_lo", 32'(stl[d]), 32'd0);
    chk("pcsrc", 32'(pcsrc[d]), 32'(b & z));
    chk("btarget", btgt[d], tgt);
    @(posedge clk); #1;
    chk("rw_out", 32'(rw_o[d]), 32'(w));
    chk("mtr_out", 32'(mtr_o[d]), 32'(m));
    chk("alu_out", alu_o[d], a);
    chk("wn_out", 32'(wn_o[d]), 32'(n));
    chk("pcn_out", pcn_o[d], pn);
    chk("misalign", 32'(mis[d]), 32'((rd | wr) & ~algn));
    if (chk_rd) chk("rd_out", rd_o[d], exp_rd);
    if (wr && algn) begin
      mem_m[d][idx] = data;
      known[d][idx] = 1;
    end
  endtask

  task automatic store(input int d, input logic [31:0] a, input logic [31:0] data);
    txn(d, 0, 2'b00, 0, 1, 0, 0, a, data, 5'd0, 32'h0, 32'h4);
  endtask

  task automatic load(input int d, input logic [31:0] a, input logic [4:0] n);
    txn(d, 1, 2'b01, 1, 0, 0, 0, a, 32'h0, n, 32'h0, 32'h8);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    for (int d = 0; d < 3; d++)
      for (int i = 0; i < 256; i++) begin
        known[d][i] = 0;
        mem_m[d][i] = 32'h0;
      end

    // Reset with random inputs: outputs must come up clear.
    reset = 1;
    rand_all();
    @(posedge clk); @(posedge clk); #1;
    reset = 0;
    idle_all();
    #1;
    for (int d = 0; d < 3; d++) begin
      chk("rst_stall", 32'(stl[d]), 32'd0);
      chk("rst_pcsrc", 32'(pcsrc[d]), 32'd0);
      chk("rst_rw", 32'(rw_o[d]), 32'd0);
      chk("rst_rd", rd_o[d], 32'h0);
      chk("rst_alu", alu_o[d], 32'h0);
      chk("rst_pcn", pcn_o[d], 32'h0);
      chk("rst_mis", 32'(mis[d]), 32'd0);
    end

    // Preload words 0..7 of every instance so all later loads are known.
    for (int d = 0; d < 3; d++)
      for (int i = 0; i < 8; i++)
        store(d, 32'(i * 4), $urandom);

    // Latency 1: store then load back.
    store(0, 32'h10, 32'hDEADBEEF);
    load(0, 32'h10, 5'd5);

    // Latency 3: store then load with 2-cycle stall each.
    store(1, 32'h10, 32'hCAFEF00D);
    load(1, 32'h10, 5'd7);

    // Branch taken / not taken.
    txn(0, 0, 2'b00, 0, 0, 1, 1, 32'h0, 32'h0, 5'd0, 32'h40, 32'h24);
    txn(0, 0, 2'b00, 0, 0, 1, 0, 32'h0, 32'h0, 5'd0, 32'h40, 32'h28);
    txn(1, 0, 2'b00, 0, 0, 1, 1, 32'h0, 32'h0, 5'd0, 32'h80, 32'h2c);

    // Misaligned store leaves word 4 intact; 0x400 wraps to word 0.
    for (int d = 0; d < 3; d++) begin
      store(d, 32'h13, 32'h11111111);
      load(d, 32'h10, 5'd3);
      store(d, 32'h400, 32'h0BADF00D);
      load(d, 32'h0, 5'd9);
    end

    // Both request bits: acts as store, RD_out zero.
    txn(2, 1, 2'b01, 1, 1, 0, 0, 32'h8, 32'h55AA55AA, 5'd2, 32'h0, 32'h30);
    load(2, 32'h8, 5'd2);

    // Reset on the 2nd stall cycle of a latency-4 store aborts it.
    idle_all();
    mw[2] = 1; alu[2] = 32'hC; rd2[2] = 32'hFFFF0000;
    #1;
    chk("abort_stall1", 32'(stl[2]), 32'd1);
    @(posedge clk); #1;
    chk("abort_stall2", 32'(stl[2]), 32'd1);
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    idle_all();
    #1;
    chk("abort_idle", 32'(stl[2]), 32'd0);
    chk("abort_rw", 32'(rw_o[2]), 32'd0);
    load(2, 32'hC, 5'd4);

    // Random instructions against the model.
    for (int t = 0; t < 150; t++) begin
      int          d, op;
      logic [31:0] a;
      bit          r, w;
      d  = int'($urandom_range(0, 2));
      op = int'($urandom_range(0, 4));
      a  = ($urandom & ~32'h3FF) | (32'($urandom_range(0, 7)) << 2);
      if ($urandom_range(0, 4) == 0) a[1:0] = 2'($urandom_range(1, 3));
      r = (op == 1) || (op == 3);
      w = (op == 2) || (op == 3);
      txn(d, 1'($urandom), 2'($urandom_range(0, 2)), r, w, op == 4, 1'($urandom),
          a, $urandom, 5'($urandom), $urandom, $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage of the 5-stage pipeline.
- Consumes the EX/MEM register outputs: control bits, ALU result, store data, destination register, branch target and PC+4.
- Contains the word-addressed data memory, resolves branches, and generates a stall for multi-cycle memory accesses.
- Registers results into the MEM/WB pipeline register for the write-back stage.

Parameters:
ADDR_W, 8, word-address width; memory depth = 2**ADDR_W 32-bit words
MEM_LAT, 1, data-memory access latency in cycles (>=1)

Ports:
clk  in  1  clock
reset  in  1  reset
RegWrite_in  in  1  WB control: register write enable
MemtoReg_in  in  2  WB control: 00 ALU, 01 memory, 10 PC+4 (link)
MemRead  in  1  load request
MemWrite  in  1  store request
Branch  in  1  branch instruction
Zero  in  1  ALU zero flag
ALU  in  32  ALU result / byte address
RD2  in  32  store data
WN  in  5  destination register
PC_ADD  in  32  branch target
pc_next_in  in  32  PC+4
PCSrc  out  1  take branch (combinational)
branch_target  out  32  equals PC_ADD (combinational)
stall  out  1  freeze PC, IF/ID, ID/EX and EX/MEM (combinational from state)
misalign  out  1  registered: last access had ALU[1:0]!=0
RegWrite_out  out  1  MEM/WB RegWrite
MemtoReg_out  out  2  MEM/WB MemtoReg
RD_out  out  32  MEM/WB load data
ALU_out  out  32  MEM/WB ALU result
WN_out  out  5  MEM/WB destination
pc_next_out  out  32  MEM/WB PC+4

Behaviour:
- Reset: reset is synchronous, active-high; clock is clk.
  - All registered outputs clear to 0; FSM returns to IDLE; latency counter clears to 0.
  - Memory contents are not cleared.
- Address: word index = ALU[ADDR_W+1:2]. Upper bits are ignored, so addresses wrap modulo depth.
- access = (MemRead | MemWrite) & (ALU[1:0]==2'b00).
- Misaligned request (MemRead|MemWrite with ALU[1:0]!=0):
  - No memory write; RD_out=0; no stall.
  - misalign=1 for that captured instruction; 0 otherwise.
  - Other fields pass through normally.
- Both MemRead and MemWrite high: treated as a store; RD_out=0.
- FSM states: IDLE, BUSY.
  - IDLE, access && MEM_LAT>1: go to BUSY, cnt<=MEM_LAT-1, stall=1.
    - MEM/WB captures a bubble: RegWrite_out=0, WN_out=0, MemtoReg_out=0, RD_out=0, ALU_out=0, pc_next_out=0.
  - BUSY, cnt>1: cnt<=cnt-1, stall=1, bubble captured.
  - BUSY, cnt==1: stall=0; this is the final access cycle. At the clock edge: store commits, load data is read, the MEM/WB register captures the real instruction, and the FSM goes to IDLE.
  - IDLE, otherwise (no access, or MEM_LAT==1): stall=0. Store commits and MEM/WB captures at the same edge (single-cycle).
- Stall timing:
  - Total occupancy is MEM_LAT cycles; stall is high for exactly MEM_LAT-1 cycles.
  - Upstream holds inputs stable while stall=1.
  - Exactly one memory write per store, regardless of MEM_LAT.
- Load data: RD_out = mem[index] sampled at the committing edge. Read is old-data if a store to the same address commits at the same edge; this cannot occur with a single access per cycle, but read-before-write is the rule.
- Branch: PCSrc = Branch & Zero & ~stall; branch_target = PC_ADD. Branches never request memory, so PCSrc is valid in IDLE.
- Pass-through fields (RegWrite, MemtoReg, ALU, WN, pc_next) are registered with 1-cycle latency on non-stall cycles.
- Reset during BUSY: FSM goes to IDLE and the pending store is aborted (memory unchanged); outputs clear.

Test Plan:
- Reset: hold reset 2 cycles with random inputs -> all outputs 0, stall=0, PCSrc=0 once reset deasserts and inputs are 0.
- MEM_LAT=1 store then load: store ALU=0x10, RD2=0xDEADBEEF; next cycle load ALU=0x10, MemtoReg_in=01, WN=5 -> RD_out=0xDEADBEEF, WN_out=5, RegWrite_out=1; stall stays 0.
- MEM_LAT=3 load: stall=1 for exactly 2 cycles with bubbles (RegWrite_out=0); on the 3rd edge RD_out holds the data; a store under the same stall pattern writes memory exactly once.
- Branch: Branch=1, Zero=1, PC_ADD=0x40 -> PCSrc=1, branch_target=0x40 same cycle; Zero=0 -> PCSrc=0.
- Misaligned and wrap: store with ALU=0x13 -> misalign=1, memory unchanged; store with ALU=0x400 (ADDR_W=8) -> written to index 0.
- Reset mid-BUSY (MEM_LAT=4) on the 2nd stall cycle of a store -> FSM IDLE, stall=0, target word unchanged on readback.
